// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: FSM state encoding, drain length and latch-control bundle.
// Optional feature macro used by pipeline_control: PIPELINE_PERF_CNT_EN.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DWAIT  = 3'd1,
    DRAIN  = 3'd2,
    HALTED = 3'd3
  } pipe_state_t;

  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } latch_ctrl_t;

  // Canonical control patterns; flushed latches always have their enable low.
  localparam latch_ctrl_t CTRL_HOLD = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_flush: 1'b0,
    exmem_en: 1'b0, exmem_flush: 1'b0, memwb_en: 1'b0, memwb_flush: 1'b0};

  localparam latch_ctrl_t CTRL_NORMAL = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1, idex_flush: 1'b0,
    exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b0};

  localparam latch_ctrl_t CTRL_DRAIN = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
    exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};

  localparam latch_ctrl_t CTRL_MISPRED = '{
    pc_en: 1'b1, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
    exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};

  localparam latch_ctrl_t CTRL_JUMP = '{
    pc_en: 1'b1, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0, idex_flush: 1'b1,
    exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b0};

  localparam latch_ctrl_t CTRL_BUBBLE = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b0, idex_flush: 1'b1,
    exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b0};

  localparam latch_ctrl_t CTRL_FETCH = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b1, idex_flush: 1'b0,
    exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1, memwb_flush: 1'b0};

endpackage

// File: rtl/pipeline_control_if.sv
// Status inputs and latch-control outputs of the pipeline controller.
// master = controller side, slave = datapath side.
interface pipeline_control_if;

  logic       ihit;
  logic       dhit;
  logic       mem_dren;
  logic       mem_dwen;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       ex_jump;
  logic       mem_mispredict;
  logic       mem_halt;

  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_flush;
  logic       exmem_en;
  logic       exmem_flush;
  logic       memwb_en;
  logic       memwb_flush;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  ihit, dhit, mem_dren, mem_dwen, ex_memread, ex_rt, id_rs, id_rt,
           ex_jump, mem_mispredict, mem_halt,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halted, state
  );

  modport slave (
    output ihit, dhit, mem_dren, mem_dwen, ex_memread, ex_rt, id_rs, id_rt,
           ex_jump, mem_mispredict, mem_halt,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwb_en, memwb_flush, halted, state
  );

endinterface

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use hazard detect: EX-stage load whose destination feeds an ID-stage source.
// Purely combinational; $zero as destination never creates a hazard.
module hazard_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_control.sv
// Pipeline latch controller: stall/flush arbitration, data-wait, halt drain. Latch controls are
// combinational from state+inputs; state/halted registered. Macro PIPELINE_PERF_CNT_EN adds perf counters.
module pipeline_control
  import cpu_types_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  pipeline_control_if.master bus
`ifdef PIPELINE_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  pipe_state_t state, state_nxt;
  logic [1:0]  drain_cnt, drain_cnt_nxt;
  logic        halted_q;
  logic        load_use;
  logic        data_wait;
  latch_ctrl_t run_ctrl;
  latch_ctrl_t ctrl;

  hazard_detect u_hazard_detect (
    .ex_memread (bus.ex_memread),
    .ex_rt      (bus.ex_rt),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .load_use   (load_use)
  );

  assign data_wait = (bus.mem_dren || bus.mem_dwen) && !bus.dhit;

  // Event arbitration for a cycle with no outstanding data access.
  always_comb begin
    run_ctrl = CTRL_NORMAL;
    if (bus.mem_halt)           run_ctrl = CTRL_DRAIN;
    else if (bus.mem_mispredict) run_ctrl = CTRL_MISPRED;
    else if (bus.ex_jump)        run_ctrl = CTRL_JUMP;
    else if (load_use)           run_ctrl = CTRL_BUBBLE;
    else if (!bus.ihit)          run_ctrl = CTRL_FETCH;
  end

  always_comb begin
    ctrl          = CTRL_HOLD;
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (data_wait) begin
          state_nxt = DWAIT;
        end else begin
          ctrl = run_ctrl;
          if (bus.mem_halt) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_CYCLES;
          end
        end
      end
      DWAIT: begin
        if (bus.dhit) begin
          ctrl      = run_ctrl;
          state_nxt = RUN;
          if (bus.mem_halt) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_CYCLES;
          end
        end
      end
      DRAIN: begin
        // A data wait freezes the drain; otherwise count down and halt on the last cycle.
        if (!data_wait) begin
          ctrl          = CTRL_DRAIN;
          drain_cnt_nxt = drain_cnt - 2'd1;
          if (drain_cnt <= 2'd1) state_nxt = HALTED;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    if (!nRST) ctrl = CTRL_HOLD;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
      halted_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      halted_q  <= (state_nxt == HALTED);
    end
  end

`ifdef PIPELINE_PERF_CNT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cycle_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (state != HALTED) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (!ctrl.pc_en) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.memwb_flush = ctrl.memwb_flush;
  assign bus.halted      = halted_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: vector table for single-cycle arbitration, hand sequences
// for data wait, reset abort, halt drain and sticky HALTED.
module tb_pipeline_control;

  localparam logic [8:0] E_HOLD   = 9'b000000000;
  localparam logic [8:0] E_NORM   = 9'b110101010;
  localparam logic [8:0] E_BUBBLE = 9'b000011010;
  localparam logic [8:0] E_MISP   = 9'b101010110;
  localparam logic [8:0] E_JUMP   = 9'b101011010;
  localparam logic [8:0] E_FETCH  = 9'b001101010;
  localparam logic [8:0] E_DRAIN  = 9'b001010110;
  localparam logic [2:0] S_RUN = 3'd0, S_DWAIT = 3'd1, S_DRAIN = 3'd2, S_HALTED = 3'd3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipeline_control_if bus ();

`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt;
  pipeline_control dut (.CLK(CLK), .nRST(nRST), .bus(bus), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt));
`else
  pipeline_control dut (.CLK(CLK), .nRST(nRST), .bus(bus));
`endif

  always #5 CLK = ~CLK;

  logic [8:0] ctrl;
  assign ctrl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                 bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_flush};

  typedef struct {
    string      nm;
    logic       ihit, dhit, dren, dwen, memread;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       jump, mispred;
    logic [8:0] exp_ctrl;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.mem_dren = 1'b0; bus.mem_dwen = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
    bus.ex_jump = 1'b0; bus.mem_mispredict = 1'b0; bus.mem_halt = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"normal",      1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_NORM};
    tbl[1]  = '{"lu_rs",       1,0,0,0,1, 5'd5, 5'd5, 5'd3, 0,0, E_BUBBLE};
    tbl[2]  = '{"lu_rt",       1,0,0,0,1, 5'd7, 5'd2, 5'd7, 0,0, E_BUBBLE};
    tbl[3]  = '{"lu_r0",       1,0,0,0,1, 5'd0, 5'd0, 5'd0, 0,0, E_NORM};
    tbl[4]  = '{"lu_nomatch",  1,0,0,0,1, 5'd5, 5'd6, 5'd4, 0,0, E_NORM};
    tbl[5]  = '{"no_memread",  1,0,0,0,0, 5'd5, 5'd5, 5'd5, 0,0, E_NORM};
    tbl[6]  = '{"jump_lu",     1,0,0,0,1, 5'd5, 5'd5, 5'd0, 1,0, E_JUMP};
    tbl[7]  = '{"misp_all",    1,0,0,0,1, 5'd5, 5'd5, 5'd0, 1,1, E_MISP};
    tbl[8]  = '{"fetch_wait",  0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_FETCH};
    tbl[9]  = '{"fetch_lu",    0,0,0,0,1, 5'd5, 5'd5, 5'd0, 0,0, E_BUBBLE};
    tbl[10] = '{"load_hit",    1,1,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, E_NORM};
    tbl[11] = '{"store_jump",  1,1,0,1,0, 5'd0, 5'd0, 5'd0, 1,0, E_JUMP};
    tbl[12] = '{"misp_fetch",  0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,1, E_MISP};

    idle();
    #1;
    chk("rst_ctrl", 32'(ctrl), 32'(E_HOLD));
    chk("rst_state", 32'(bus.state), 32'(S_RUN));
    chk("rst_halted", 32'(bus.halted), 32'd0);
    @(negedge CLK); nRST = 1'b1; #1;
    chk("post_rst_ctrl", 32'(ctrl), 32'(E_NORM));

`ifdef PIPELINE_PERF_CNT_EN
    for (int i = 0; i < 10; i++) begin
      bus.ihit = (i >= 3);
      @(negedge CLK);
    end
    chk("cycle_cnt", cycle_cnt, 32'd10);
    chk("stall_cnt", stall_cnt, 32'd3);
    idle();
`endif

    foreach (tbl[i]) begin
      @(negedge CLK);
      bus.ihit = tbl[i].ihit; bus.dhit = tbl[i].dhit; bus.mem_dren = tbl[i].dren;
      bus.mem_dwen = tbl[i].dwen; bus.ex_memread = tbl[i].memread; bus.ex_rt = tbl[i].ex_rt;
      bus.id_rs = tbl[i].id_rs; bus.id_rt = tbl[i].id_rt; bus.ex_jump = tbl[i].jump;
      bus.mem_mispredict = tbl[i].mispred; bus.mem_halt = 1'b0;
      #1;
      chk({"vec_", tbl[i].nm}, 32'(ctrl), 32'(tbl[i].exp_ctrl));
      chk({"vec_state_", tbl[i].nm}, 32'(bus.state), 32'(S_RUN));
    end

    // Load miss: three wait cycles, then the hit cycle advances everything.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); idle(); bus.mem_dren = 1'b1; bus.dhit = 1'b0; #1;
      chk("dwait_ctrl", 32'(ctrl), 32'(E_HOLD));
      if (i > 0) chk("dwait_state", 32'(bus.state), 32'(S_DWAIT));
    end
    @(negedge CLK); bus.dhit = 1'b1; #1;
    chk("dhit_ctrl", 32'(ctrl), 32'(E_NORM));
    chk("dhit_state", 32'(bus.state), 32'(S_DWAIT));
    @(negedge CLK); idle(); #1;
    chk("after_dhit_state", 32'(bus.state), 32'(S_RUN));

    // Reset in the middle of a data wait, without a clock edge.
    @(negedge CLK); bus.mem_dren = 1'b1; bus.dhit = 1'b0;
    @(negedge CLK); #1;
    chk("pre_abort_state", 32'(bus.state), 32'(S_DWAIT));
    #2 nRST = 1'b0; #1;
    chk("abort_state", 32'(bus.state), 32'(S_RUN));
    chk("abort_ctrl", 32'(ctrl), 32'(E_HOLD));
    @(negedge CLK); idle(); nRST = 1'b1; #1;
    chk("abort_release_ctrl", 32'(ctrl), 32'(E_NORM));

    // Halt with a data wait inside the drain: counter must freeze.
    @(negedge CLK); bus.mem_halt = 1'b1; bus.mem_mispredict = 1'b1; #1;
    chk("halt_ctrl", 32'(ctrl), 32'(E_DRAIN));
    @(negedge CLK); idle(); bus.mem_dren = 1'b1; #1;
    chk("drain_wait_ctrl", 32'(ctrl), 32'(E_HOLD));
    chk("drain_wait_state", 32'(bus.state), 32'(S_DRAIN));
    @(negedge CLK); #1;
    chk("drain_wait2_state", 32'(bus.state), 32'(S_DRAIN));
    @(negedge CLK); idle(); #1;
    chk("drain_a_ctrl", 32'(ctrl), 32'(E_DRAIN));
    chk("drain_a_state", 32'(bus.state), 32'(S_DRAIN));
    @(negedge CLK); #1;
    chk("drain_b_state", 32'(bus.state), 32'(S_DRAIN));
    @(negedge CLK); #1;
    chk("wait_halted_state", 32'(bus.state), 32'(S_HALTED));
    chk("wait_halted_flag", 32'(bus.halted), 32'd1);
    nRST = 1'b0; #1;
    chk("halt_reset_flag", 32'(bus.halted), 32'd0);
    @(negedge CLK); nRST = 1'b1;

    // Plain halt: two drain cycles, then sticky HALTED.
    @(negedge CLK); idle(); bus.mem_halt = 1'b1; #1;
    chk("halt2_state", 32'(bus.state), 32'(S_RUN));
    @(negedge CLK); idle(); #1;
    chk("drain1_ctrl", 32'(ctrl), 32'(E_DRAIN));
    chk("drain1_state", 32'(bus.state), 32'(S_DRAIN));
    chk("drain1_halted", 32'(bus.halted), 32'd0);
    @(negedge CLK); #1;
    chk("drain2_state", 32'(bus.state), 32'(S_DRAIN));
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      bus.ihit = i[0]; bus.dhit = ~i[0]; bus.mem_dren = i[1];
      bus.mem_halt = i[0]; bus.mem_mispredict = i[1]; #1;
      chk("halted_state", 32'(bus.state), 32'(S_HALTED));
      chk("halted_flag", 32'(bus.halted), 32'd1);
      chk("halted_ctrl", 32'(ctrl), 32'(E_HOLD));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
